// File: rtl/wb_ctrl_pkg.sv
// Shared constants for the Fibonacci Wishbone register window: register offsets,
// the ID word, interrupt bit positions and a byte-lane merge helper.
package wb_ctrl_pkg;

  localparam int OFF_NR         = 'h00;
  localparam int OFF_ID         = 'h04;
  localparam int OFF_CTRL       = 'h08;
  localparam int OFF_CLOCK      = 'h0C;
  localparam int OFF_IRQ_MASK   = 'h10;
  localparam int OFF_IRQ_STATUS = 'h14;
  localparam int OFF_SWI        = 'h18;
  localparam int OFF_SCRATCH    = 'h20;
  localparam int OFF_VAL        = 'h40;
  localparam int OFF_THRESH     = 'h60;

  localparam logic [31:0] ID_VALUE = 32'h4669_626f;

  localparam int IRQ_THRESH = 0;
  localparam int IRQ_WRAP   = 1;
  localparam int IRQ_SWI    = 2;
  localparam int NUM_IRQ    = 3;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_d,
                                             input logic [31:0] new_d,
                                             input logic [3:0]  sel);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{sel[b]}};
    return (old_d & ~m) | (new_d & m);
  endfunction

endpackage

// File: rtl/wb_irq_ctrl.sv
// Sticky interrupt status with write-1-to-clear and a registered, masked irq output.
// Events are registered once before landing in status; a set beats a same-edge clear.
module wb_irq_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic             wb_clk_i,
  input  logic             reset,
  input  logic [WIDTH-1:0] evt,
  input  logic [WIDTH-1:0] clr,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] status,
  output logic [WIDTH-1:0] irq
);

  logic [WIDTH-1:0] evt_q;

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      evt_q  <= '0;
      status <= '0;
      irq    <= '0;
    end else begin
      evt_q  <= evt;
      status <= (status & ~clr) | evt_q;
      irq    <= status & mask;
    end
  end

endmodule

// File: rtl/wb_ctrl_regs.sv
// Wishbone control/status register file for the Fibonacci engines: channel enables,
// clock select, scratch, per-channel value/threshold and the interrupt sources.
module wb_ctrl_regs
  import wb_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS  = 32'h3000_0000,
  parameter int          ADDR_BITS     = 8,
  parameter int          NUM_CH        = 2,
  parameter int          VAL_WIDTH     = 30,
  parameter int          CLOCK_WIDTH   = 6,
  parameter int          SCRATCH_DEPTH = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          reset,
  input  logic                          wbs_stb_i,
  input  logic                          wbs_cyc_i,
  input  logic                          wbs_we_i,
  input  logic [3:0]                    wbs_sel_i,
  input  logic [31:0]                   wbs_adr_i,
  input  logic [31:0]                   wbs_dat_i,
  output logic                          wbs_ack_o,
  output logic [31:0]                   wbs_dat_o,
  input  logic [NUM_CH*VAL_WIDTH-1:0]   val_i,
  output logic [NUM_CH-1:0]             ch_en_o,
  output logic [CLOCK_WIDTH-1:0]        clock_sel_o,
  output logic [2:0]                    irq
);

  localparam logic [31:0] NUM_REGS = 32'(7 + SCRATCH_DEPTH + 2 * NUM_CH);

  logic                   hit, wr;
  logic [ADDR_BITS-1:0]   off;
  logic                   unused_adr;
  logic [NUM_CH-1:0]      ctrl_q;
  logic [CLOCK_WIDTH-1:0] clock_q;
  logic [2:0]             mask_q, status, evt, clr;
  logic [31:0]            scratch_q [SCRATCH_DEPTH];
  logic [VAL_WIDTH-1:0]   thresh_q  [NUM_CH];
  logic [VAL_WIDTH-1:0]   val_prev  [NUM_CH];
  logic [VAL_WIDTH-1:0]   val_cur   [NUM_CH];
  logic [31:0]            rdata;

  // The ack term keeps a held strobe from hitting on the cycle its ack is showing.
  assign hit = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o &
               (wbs_adr_i[31:ADDR_BITS] == BASE_ADDRESS[31:ADDR_BITS]);
  assign wr  = hit & wbs_we_i;
  assign off = {wbs_adr_i[ADDR_BITS-1:2], 2'b00};
  assign unused_adr = ^wbs_adr_i[1:0];

  assign ch_en_o     = ctrl_q;
  assign clock_sel_o = clock_q;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) val_cur[c] = val_i[c*VAL_WIDTH +: VAL_WIDTH];
  end

  always_comb begin
    rdata = '0;
    if (off == ADDR_BITS'(OFF_NR))         rdata = NUM_REGS;
    if (off == ADDR_BITS'(OFF_ID))         rdata = ID_VALUE;
    if (off == ADDR_BITS'(OFF_CTRL))       rdata = 32'(ctrl_q);
    if (off == ADDR_BITS'(OFF_CLOCK))      rdata = 32'(clock_q);
    if (off == ADDR_BITS'(OFF_IRQ_MASK))   rdata = 32'(mask_q);
    if (off == ADDR_BITS'(OFF_IRQ_STATUS)) rdata = 32'(status);
    for (int k = 0; k < SCRATCH_DEPTH; k++)
      if (off == ADDR_BITS'(OFF_SCRATCH + 4 * k)) rdata = scratch_q[k];
    for (int c = 0; c < NUM_CH; c++) begin
      if (off == ADDR_BITS'(OFF_VAL + 4 * c))    rdata = 32'(val_cur[c]);
      if (off == ADDR_BITS'(OFF_THRESH + 4 * c)) rdata = 32'(thresh_q[c]);
    end
  end

  // Threshold crossing compares both samples against the current threshold, so
  // rewriting a threshold alone never raises an event.
  always_comb begin
    evt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if ((val_cur[c] >= thresh_q[c]) && (val_prev[c] < thresh_q[c])) evt[IRQ_THRESH] = 1'b1;
      if (ctrl_q[c] && (val_cur[c] < val_prev[c]))                      evt[IRQ_WRAP]   = 1'b1;
    end
    evt[IRQ_SWI] = wr && (off == ADDR_BITS'(OFF_SWI)) && wbs_sel_i[0] && wbs_dat_i[0];
  end

  assign clr = (wr && (off == ADDR_BITS'(OFF_IRQ_STATUS)) && wbs_sel_i[0]) ? wbs_dat_i[2:0] : 3'b000;

  always_ff @(posedge wb_clk_i) begin
    for (int c = 0; c < NUM_CH; c++) val_prev[c] <= val_cur[c];
    if (reset) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      ctrl_q    <= '1;
      clock_q   <= CLOCK_WIDTH'(1);
      mask_q    <= '0;
      for (int k = 0; k < SCRATCH_DEPTH; k++) scratch_q[k] <= '0;
      for (int c = 0; c < NUM_CH; c++)        thresh_q[c]  <= '1;
    end else begin
      wbs_ack_o <= hit;
      wbs_dat_o <= (hit && !wbs_we_i) ? rdata : '0;
      if (wr) begin
        if (off == ADDR_BITS'(OFF_CTRL))
          ctrl_q <= NUM_CH'(byte_merge(32'(ctrl_q), wbs_dat_i, wbs_sel_i));
        if (off == ADDR_BITS'(OFF_CLOCK))
          clock_q <= CLOCK_WIDTH'(byte_merge(32'(clock_q), wbs_dat_i, wbs_sel_i));
        if (off == ADDR_BITS'(OFF_IRQ_MASK))
          mask_q <= 3'(byte_merge(32'(mask_q), wbs_dat_i, wbs_sel_i));
        for (int k = 0; k < SCRATCH_DEPTH; k++)
          if (off == ADDR_BITS'(OFF_SCRATCH + 4 * k))
            scratch_q[k] <= byte_merge(scratch_q[k], wbs_dat_i, wbs_sel_i);
        for (int c = 0; c < NUM_CH; c++)
          if (off == ADDR_BITS'(OFF_THRESH + 4 * c))
            thresh_q[c] <= VAL_WIDTH'(byte_merge(32'(thresh_q[c]), wbs_dat_i, wbs_sel_i));
      end
    end
  end

  wb_irq_ctrl #(.WIDTH(NUM_IRQ)) u_irq (
    .wb_clk_i (wb_clk_i),
    .reset    (reset),
    .evt      (evt),
    .clr      (clr),
    .mask     (mask_q),
    .status   (status),
    .irq      (irq)
  );

endmodule

// File: tb/tb_wb_ctrl_regs.sv
// Bench for wb_ctrl_regs: directed interrupt/bus scenarios plus a randomized
// register-map walk checked against a simple array model of the register file.
module tb_wb_ctrl_regs;

  localparam logic [31:0] BASE          = 32'h3000_0000;
  localparam int          ADDR_BITS     = 8;
  localparam int          NUM_CH        = 2;
  localparam int          VAL_WIDTH     = 30;
  localparam int          CLOCK_WIDTH   = 6;
  localparam int          SCRATCH_DEPTH = 4;
  localparam logic [31:0] NR_EXP        = 32'(7 + SCRATCH_DEPTH + 2 * NUM_CH);
  localparam logic [31:0] ID_EXP        = 32'h4669_626f;
  localparam logic [31:0] VAL_MASK      = 32'((64'h1 << VAL_WIDTH) - 1);
  localparam logic [31:0] CTRL_MASK     = 32'((64'h1 << NUM_CH) - 1);
  localparam logic [31:0] CLK_MASK      = 32'((64'h1 << CLOCK_WIDTH) - 1);

  logic                        wb_clk_i = 1'b0;
  logic                        reset    = 1'b1;
  logic                        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]                  wbs_sel_i = 4'h0;
  logic [31:0]                 wbs_adr_i = '0, wbs_dat_i = '0;
  logic                        wbs_ack_o;
  logic [31:0]                 wbs_dat_o;
  logic [NUM_CH*VAL_WIDTH-1:0] val_i = '0;
  logic [NUM_CH-1:0]           ch_en_o;
  logic [CLOCK_WIDTH-1:0]      clock_sel_o;
  logic [2:0]                  irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_ctrl, m_clock, m_mask;
  logic [31:0] m_scratch [SCRATCH_DEPTH];
  logic [31:0] m_thresh  [NUM_CH];

  wb_ctrl_regs #(
    .BASE_ADDRESS(BASE), .ADDR_BITS(ADDR_BITS), .NUM_CH(NUM_CH),
    .VAL_WIDTH(VAL_WIDTH), .CLOCK_WIDTH(CLOCK_WIDTH), .SCRATCH_DEPTH(SCRATCH_DEPTH)
  ) dut (
    .wb_clk_i(wb_clk_i), .reset(reset),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .val_i(val_i), .ch_en_o(ch_en_o), .clock_sel_o(clock_sel_o), .irq(irq)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] merge(input logic [31:0] old_d, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r = old_d;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] off);
    int o = int'(off);
    if (o == 'h00) return NR_EXP;
    if (o == 'h04) return ID_EXP;
    if (o == 'h08) return m_ctrl;
    if (o == 'h0C) return m_clock;
    if (o == 'h10) return m_mask;
    if (o >= 'h20 && o < 'h20 + 4 * SCRATCH_DEPTH) return m_scratch[(o - 'h20) / 4];
    if (o >= 'h40 && o < 'h40 + 4 * NUM_CH) return 32'(val_i[((o - 'h40) / 4) * VAL_WIDTH +: VAL_WIDTH]);
    if (o >= 'h60 && o < 'h60 + 4 * NUM_CH) return m_thresh[(o - 'h60) / 4];
    return 32'h0;
  endfunction

  task automatic set_val(input int c, input logic [31:0] v);
    val_i[c*VAL_WIDTH +: VAL_WIDTH] = VAL_WIDTH'(v);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  // One transaction from a negedge: ack must show for exactly the cycle after the sampling edge.
  task automatic xfer(input logic we, input logic [7:0] off, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd);
    logic ack1;
    wbs_adr_i = BASE | 32'(off); wbs_dat_i = dat; wbs_sel_i = sel; wbs_we_i = we;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    @(posedge wb_clk_i); @(negedge wb_clk_i);
    ack1 = wbs_ack_o; rd = wbs_dat_o;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge wb_clk_i);
    n_checks++;
    if (ack1 !== 1'b1 || wbs_ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_pulse off=%h: ack got %b then %b, want 1 then 0", off, ack1, wbs_ack_o);
    end
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] d;
    xfer(1'b1, off, dat, sel, d);
  endtask

  task automatic wb_read(input logic [7:0] off, output logic [31:0] d);
    xfer(1'b0, off, 32'h0, 4'hF, d);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    n_checks++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0 || irq !== 3'b0 ||
        ch_en_o !== NUM_CH'(CTRL_MASK) || clock_sel_o !== CLOCK_WIDTH'(1)) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b dat=%h irq=%b ch_en=%b clk=%h, want 0 0 000 all-ones 1",
               wbs_ack_o, wbs_dat_o, irq, ch_en_o, clock_sel_o);
    end
    reset = 1'b0;
    wb_read(8'h04, d);
    n_checks++; if (d !== ID_EXP) begin n_fail++; $display("FAIL read_id: got %h want %h", d, ID_EXP); end
    wb_read(8'h08, d);
    n_checks++; if (d !== CTRL_MASK) begin n_fail++; $display("FAIL read_ctrl: got %h want %h", d, CTRL_MASK); end
    wb_read(8'h0C, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL read_clock: got %h want 1", d); end
    wb_read(8'h00, d);
    n_checks++; if (d !== NR_EXP) begin n_fail++; $display("FAIL read_nr: got %h want %h", d, NR_EXP); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    wb_write(8'h20, 32'hAABB_CCDD, 4'b0101);
    wb_read(8'h20, d);
    n_checks++; if (d !== 32'h00BB_00DD) begin n_fail++; $display("FAIL sel_write: got %h want 00bb00dd", d); end
  endtask

  task automatic test_miss();
    int acks = 0;
    wbs_adr_i = BASE + 32'h100; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    repeat (8) begin @(negedge wb_clk_i); if (wbs_ack_o) acks++; end
    wbs_adr_i = BASE + 32'h108; wbs_we_i = 1'b1; wbs_dat_i = 32'h0;
    repeat (8) begin @(negedge wb_clk_i); if (wbs_ack_o) acks++; end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge wb_clk_i);
    n_checks++; if (acks != 0) begin n_fail++; $display("FAIL miss_ack: got %0d acks want 0", acks); end
    n_checks++;
    if (ch_en_o !== NUM_CH'(CTRL_MASK)) begin n_fail++; $display("FAIL miss_side_effect: ch_en=%b want all ones", ch_en_o); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] acks;
    logic [31:0] d0, d2;
    wbs_adr_i = BASE + 32'h20; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk_i); @(negedge wb_clk_i);
      acks[i] = wbs_ack_o;
      if (i == 0) d0 = wbs_dat_o;
      if (i == 2) d2 = wbs_dat_o;
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    @(negedge wb_clk_i);
    n_checks++; if (acks !== 4'b0101) begin n_fail++; $display("FAIL b2b_ack: got %b want 0101", acks); end
    n_checks++;
    if (d0 !== 32'h00BB_00DD || d2 !== 32'h00BB_00DD) begin
      n_fail++; $display("FAIL b2b_data: got %h %h want 00bb00dd", d0, d2);
    end
  endtask

  task automatic test_thresh_irq();
    logic [31:0] d;
    wb_write(8'h64, 32'd100, 4'hF);
    wb_write(8'h10, 32'h1, 4'hF);
    for (int v = 98; v <= 101; v++) begin
      set_val(1, 32'(v));
      cycles(3);
      if (v == 99) begin
        n_checks++; if (irq !== 3'b000) begin n_fail++; $display("FAIL thresh_early: irq=%b want 000", irq); end
      end
    end
    n_checks++; if (irq !== 3'b001) begin n_fail++; $display("FAIL thresh_irq: irq=%b want 001", irq); end
    wb_read(8'h14, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL thresh_status: got %h want 1", d); end
    wb_write(8'h14, 32'h1, 4'hF);
    cycles(4);
    n_checks++; if (irq !== 3'b000) begin n_fail++; $display("FAIL thresh_w1c_irq: irq=%b want 000", irq); end
    wb_read(8'h14, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL thresh_w1c_status: got %h want 0", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    set_val(0, 32'd500); cycles(2);
    set_val(0, 32'd3);   cycles(3);
    wb_read(8'h14, d);
    n_checks++; if (d !== 32'h2) begin n_fail++; $display("FAIL wrap_enabled: status %h want 2", d); end
    n_checks++; if (irq !== 3'b000) begin n_fail++; $display("FAIL wrap_masked_irq: irq=%b want 000", irq); end
    wb_write(8'h14, 32'h2, 4'hF);
    wb_write(8'h08, 32'h2, 4'hF);
    set_val(0, 32'd500); cycles(2);
    set_val(0, 32'd3);   cycles(3);
    wb_read(8'h14, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL wrap_disabled: status %h want 0", d); end
    n_checks++; if (ch_en_o !== 2'b10) begin n_fail++; $display("FAIL ctrl_out: ch_en=%b want 10", ch_en_o); end
  endtask

  task automatic test_swi();
    logic [31:0] d;
    logic [2:0] irq_t1, irq_t2;
    wb_write(8'h10, 32'h0, 4'hF);
    wb_write(8'h18, 32'h1, 4'hF);
    cycles(2);
    n_checks++; if (irq !== 3'b000) begin n_fail++; $display("FAIL swi_masked_irq: irq=%b want 000", irq); end
    wb_read(8'h14, d);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL swi_status: got %h want 4", d); end
    wb_read(8'h18, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL swi_read: got %h want 0", d); end
    wbs_adr_i = BASE + 32'h10; wbs_dat_i = 32'h4; wbs_sel_i = 4'hF; wbs_we_i = 1'b1;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    @(posedge wb_clk_i); @(negedge wb_clk_i);
    irq_t1 = irq;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge wb_clk_i); @(negedge wb_clk_i);
    irq_t2 = irq;
    n_checks++;
    if (irq_t1 !== 3'b000 || irq_t2 !== 3'b100) begin
      n_fail++; $display("FAIL unmask_latency: irq %b then %b, want 000 then 100", irq_t1, irq_t2);
    end
  endtask

  // A wrap event is lined up so it lands in status on the same edge as a W1C of that bit.
  task automatic test_set_wins();
    logic [31:0] d;
    wb_write(8'h08, 32'h3, 4'hF);
    set_val(0, 32'd500); cycles(2);
    set_val(0, 32'd3);   cycles(3);
    set_val(0, 32'd500); cycles(2);
    set_val(0, 32'd3);
    @(posedge wb_clk_i); @(negedge wb_clk_i);
    wb_write(8'h14, 32'h2, 4'hF);
    wb_read(8'h14, d);
    n_checks++; if (d !== 32'h6) begin n_fail++; $display("FAIL set_wins: status %h want 6", d); end
    wb_write(8'h14, 32'h6, 4'hF);
    wb_read(8'h14, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_after_set: status %h want 0", d); end
  endtask

  task automatic test_random_regs();
    logic [31:0] d, exp_d;
    logic [7:0]  off;
    logic [3:0]  sel;
    logic [7:0]  pool [20] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h18, 8'h1C, 8'h20, 8'h24, 8'h28,
                               8'h2C, 8'h30, 8'h40, 8'h44, 8'h48, 8'h60, 8'h64, 8'h68, 8'h80, 8'hFC};
    for (int c = 0; c < NUM_CH; c++) set_val(c, $urandom);
    reset = 1'b1;
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    reset = 1'b0;
    m_ctrl = CTRL_MASK; m_clock = 32'h1; m_mask = 32'h0;
    for (int k = 0; k < SCRATCH_DEPTH; k++) m_scratch[k] = 32'h0;
    for (int c = 0; c < NUM_CH; c++)        m_thresh[c]  = VAL_MASK;
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom; sel = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 4))
          0: begin off = 8'h08; m_ctrl  = merge(m_ctrl, d, sel) & CTRL_MASK; end
          1: begin off = 8'h0C; m_clock = merge(m_clock, d, sel) & CLK_MASK; end
          2: begin off = 8'h10; m_mask  = merge(m_mask, d, sel) & 32'h7; end
          3: begin
            automatic int k = $urandom_range(0, SCRATCH_DEPTH - 1);
            off = 8'(8'h20 + 4 * k); m_scratch[k] = merge(m_scratch[k], d, sel);
          end
          default: begin
            automatic int c = $urandom_range(0, NUM_CH - 1);
            off = 8'(8'h60 + 4 * c); m_thresh[c] = merge(m_thresh[c], d, sel) & VAL_MASK;
          end
        endcase
        wb_write(off, d, sel);
        n_checks++;
        if (ch_en_o !== m_ctrl[NUM_CH-1:0] || clock_sel_o !== m_clock[CLOCK_WIDTH-1:0]) begin
          n_fail++; $display("FAIL rand_outputs: ch_en=%b clk=%h want %b %h", ch_en_o, clock_sel_o,
                             m_ctrl[NUM_CH-1:0], m_clock[CLOCK_WIDTH-1:0]);
        end
      end else begin
        off = pool[$urandom_range(0, 19)];
        exp_d = model_read(off);
        wb_read(off, d);
        n_checks++;
        if (d !== exp_d) begin n_fail++; $display("FAIL rand_read off=%h: got %h want %h", off, d, exp_d); end
      end
    end
    for (int c = 0; c < NUM_CH; c++) set_val(c, 32'h0);
    cycles(2);
  endtask

  task automatic test_reset_mid_strobe();
    logic [31:0] d;
    wb_write(8'h08, 32'h0, 4'hF);
    wb_write(8'h0C, 32'h5, 4'hF);
    wb_write(8'h10, 32'h4, 4'hF);
    wb_write(8'h18, 32'h1, 4'hF);
    cycles(2);
    n_checks++; if (irq !== 3'b100) begin n_fail++; $display("FAIL pre_reset_irq: irq=%b want 100", irq); end
    wbs_adr_i = BASE + 32'h04; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; reset = 1'b1;
    @(posedge wb_clk_i); @(negedge wb_clk_i);
    n_checks++;
    if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0 || irq !== 3'b0 ||
        ch_en_o !== NUM_CH'(CTRL_MASK) || clock_sel_o !== CLOCK_WIDTH'(1)) begin
      n_fail++;
      $display("FAIL reset_mid_strobe: ack=%b dat=%h irq=%b ch_en=%b clk=%h, want 0 0 000 all-ones 1",
               wbs_ack_o, wbs_dat_o, irq, ch_en_o, clock_sel_o);
    end
    @(negedge wb_clk_i);
    reset = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
    @(negedge wb_clk_i);
    n_checks++; if (wbs_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_dropped_ack: ack=%b want 0", wbs_ack_o); end
    wb_read(8'h14, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", d); end
    wb_read(8'h20, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_scratch: got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_miss();
    test_back_to_back();
    test_thresh_irq();
    test_wrap();
    test_swi();
    test_set_wins();
    test_random_regs();
    test_reset_mid_strobe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
